pingpong_row_fetch: RTL and testbench

Fetches a run of rows, each ARR_LENGTH words, from a single-port memory and assembles them into a two-bank ping-pong row buffer. It generalises the earlier single-stream fetcher in three ways: programmable base address and row count, a proper valid/ready consumer interface, and back-pressure when both banks are full. It sits between the operand memory and the matrix-multiply datapath; the datapath consumes one full row per handshake.

---
 rtl/pingpong_pkg.sv | 23 ++
 rtl/pingpong_row_fetch_row_bank.sv | 40 ++++
 rtl/pingpong_row_fetch.sv | 132 +++++++++++++
 tb/tb_pingpong_row_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared types and sizing helpers for the ping-pong row fetcher.
// The package localparams describe the default geometry; the modules derive their own from parameters.
package pingpong_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DRAIN = 3'd4
   } state_t;

   localparam int ARR_LENGTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int ROW_BITS       = ARR_LENGTH_DEF * DATA_WIDTH_DEF;
   localparam int WCNT_W         = $clog2(ARR_LENGTH_DEF);

   // A one-word row still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pingpong_row_fetch_row_bank.sv
// One bank of the ping-pong buffer: word storage with an indexed write port
// and a full flag driven by set/clear strobes.
module row_bank
   import pingpong_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ARR_LENGTH = 8,
   parameter int IDX_W      = cnt_width(ARR_LENGTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             we,
   input  logic [IDX_W-1:0]                 widx,
   input  logic [DATA_WIDTH-1:0]            wdata,
   input  logic                             set_full,
   input  logic                             clr_full,
   output logic                             full,
   output logic [ARR_LENGTH*DATA_WIDTH-1:0] data
);

   logic [ARR_LENGTH-1:0][DATA_WIDTH-1:0] words;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         words <= '0;
         full  <= 1'b0;
      end else begin
         if (we)
            words[widx] <= wdata;
         // Set and clear never target the same bank in one cycle; set wins regardless.
         if (set_full)
            full <= 1'b1;
         else if (clr_full)
            full <= 1'b0;
      end
   end

   assign data = words;

endmodule

// File: rtl/pingpong_row_fetch.sv
// Fetches row_count rows of ARR_LENGTH words from a single-port memory into a
// two-bank ping-pong buffer, presenting whole rows on a valid/ready interface.
module pingpong_row_fetch
   import pingpong_pkg::*;
#(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 8,
   parameter int ARR_LENGTH    = 8,
   parameter int ROW_CNT_WIDTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            base_addr,
   input  logic [ROW_CNT_WIDTH-1:0]         row_count,
   output logic                             busy,
   output logic                             done,
   input  logic                             mem_busy,
   output logic                             mem_req,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   input  logic [DATA_WIDTH-1:0]            mem_rdata,
   input  logic                             mem_rvalid,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ARR_LENGTH*DATA_WIDTH-1:0] out_data,
   output logic                             out_bank
);

   localparam int ROW_W = ARR_LENGTH * DATA_WIDTH;
   localparam int WC_W  = cnt_width(ARR_LENGTH);
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(ARR_LENGTH - 1);

   state_t                   state, state_nxt;
   logic [ADDR_WIDTH-1:0]    addr;
   logic [ROW_CNT_WIDTH-1:0] rows_left;
   logic [WC_W-1:0]          word_cnt;
   logic                     wr_bank, rd_bank;
   logic [1:0]               bank_full, bank_we;
   logic [1:0][ROW_W-1:0]    bank_data;
   logic                     word_in, row_done, drained, pop;

   assign word_in  = (state == WAIT) && mem_rvalid;
   assign row_done = word_in && (word_cnt == LAST_WORD);
   assign drained  = (bank_full == 2'b00);
   assign pop      = out_valid && out_ready;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign bank_we[b] = word_in && (wr_bank == 1'(b));
      row_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .ARR_LENGTH (ARR_LENGTH),
         .IDX_W      (WC_W)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .we       (bank_we[b]),
         .widx     (word_cnt),
         .wdata    (mem_rdata),
         .set_full (bank_we[b] && row_done),
         .clr_full (pop && (rd_bank == 1'(b))),
         .full     (bank_full[b]),
         .data     (bank_data[b])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (row_count == '0) ? DRAIN : REQ;
         REQ:     if (!mem_busy) state_nxt = WAIT;
         WAIT:    if (mem_rvalid) state_nxt = row_done ? CHECK : REQ;
         CHECK: begin
            if (rows_left == '0)         state_nxt = DRAIN;
            else if (!bank_full[wr_bank]) state_nxt = REQ;
         end
         DRAIN:   if (drained) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_req   = (state == REQ);
      out_valid = bank_full[rd_bank];
      out_data  = bank_data[rd_bank];
      out_bank  = rd_bank;
   end

   assign mem_addr = addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr      <= '0;
         rows_left <= '0;
         word_cnt  <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               addr      <= base_addr;
               rows_left <= row_count;
               busy      <= 1'b1;
            end
            REQ: if (!mem_busy) addr <= addr + 1'b1;
            WAIT: if (mem_rvalid) begin
               if (row_done) begin
                  word_cnt  <= '0;
                  rows_left <= rows_left - 1'b1;
                  wr_bank   <= ~wr_bank;
               end else begin
                  word_cnt  <= word_cnt + 1'b1;
               end
            end
            DRAIN: if (drained) begin
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
         if (pop) rd_bank <= ~rd_bank;
      end
   end

endmodule

// File: tb/tb_pingpong_row_fetch.sv
// Randomized scoreboard bench for pingpong_row_fetch: expected addresses, rows
// and bank indices are derived from the memory image and the transfer arguments.
module tb_pingpong_row_fetch;

   localparam int AW = 8, DW = 8, AL = 8, RW = 8;

   logic               clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [AW-1:0]      base_addr = '0;
   logic [RW-1:0]      row_count = '0;
   logic               busy, done, mem_req, out_valid, out_bank;
   logic               mem_busy = 1'b0, mem_rvalid = 1'b0, out_ready = 1'b0;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_rdata = '0;
   logic [AL*DW-1:0]   out_data;

   pingpong_row_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARR_LENGTH(AL), .ROW_CNT_WIDTH(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
      .busy(busy), .done(done), .mem_busy(mem_busy), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_bank(out_bank)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;
   logic [DW-1:0]    mem [256];
   logic [AW-1:0]    exp_addr [$];
   logic [AL*DW-1:0] exp_row [$];
   bit               exp_bank [$];
   bit               bank_par = 1'b0;
   int               done_cnt = 0, last_done_cyc = 0, rv_cnt = 0, start_cyc = 0;
   int               busy_until = 0, ready_mode = 0;
   bit               rnd_busy = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Input driver: mem_busy and out_ready change just after each rising edge.
   initial forever begin
      @(posedge clk); #1;
      mem_busy = (cyc < busy_until) || (rnd_busy && ($urandom_range(0, 3) == 0));
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Memory model: one outstanding read, 1..3 cycles of latency.
   initial forever begin
      logic [AW-1:0] a;
      int lat;
      @(negedge clk);
      if (rst && mem_req && !mem_busy) begin
         a   = mem_addr;
         lat = $urandom_range(0, 2);
         @(posedge clk);
         repeat (lat) @(posedge clk);
         #1 mem_rdata = mem[a]; mem_rvalid = 1'b1;
         @(posedge clk);
         #1 mem_rvalid = 1'b0;
      end
   end

   // Monitor: compares requests and delivered rows against the expectation queues.
   initial begin
      bit            p_stall, p_hold;
      logic [AW-1:0] p_addr;
      logic [AL*DW-1:0] p_row;
      p_stall = 0; p_hold = 0; p_addr = '0; p_row = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            p_stall = 0; p_hold = 0;
            continue;
         end
         if (mem_rvalid) rv_cnt++;
         if (p_stall) begin
            chk("req_held", mem_req, 1);
            chk("addr_held", mem_addr, p_addr);
         end
         if (p_hold) begin
            chk("valid_held", out_valid, 1);
            chk("row_held", out_data, p_row);
         end
         if (mem_req && !mem_busy) begin
            if (exp_addr.size() == 0) chk("unexpected_req", mem_addr, 64'hdead);
            else chk("req_addr", mem_addr, exp_addr.pop_front());
         end
         if (out_valid && out_ready) begin
            if (exp_row.size() == 0) chk("unexpected_row", out_data, 64'hdead);
            else begin
               chk("row_data", out_data, exp_row.pop_front());
               chk("row_bank", out_bank, exp_bank.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         p_stall = mem_req && mem_busy;
         p_addr  = mem_addr;
         p_hold  = out_valid && !out_ready;
         p_row   = out_data;
      end
   end

   task automatic pulse_start(input logic [AW-1:0] b, input logic [RW-1:0] n);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; row_count = n;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_start(input logic [AW-1:0] b, input logic [RW-1:0] n);
      logic [AL*DW-1:0] row;
      logic [AW-1:0]    a;
      for (int r = 0; r < int'(n); r++) begin
         row = '0;
         for (int k = 0; k < AL; k++) begin
            a = AW'(int'(b) + r * AL + k);
            exp_addr.push_back(a);
            row[k*DW +: DW] = mem[a];
         end
         exp_row.push_back(row);
         exp_bank.push_back(bank_par);
         bank_par = ~bank_par;
      end
      pulse_start(b, n);
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == d0) chk("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt, d0 + 1);
      chk("busy_low", busy, 0);
   endtask

   task automatic reset_outputs_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_bank"}, out_bank, 0);
      chk({tag, "_out_data"}, out_data, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, r0, n;
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
      repeat (3) @(posedge clk);
      #1 reset_outputs_zero("reset");
      @(negedge clk) rst = 1'b1;

      // Basic two-row transfer with a free-running consumer.
      ready_mode = 0;
      d0 = done_cnt; run_start(8'h10, 2); wait_done(d0);

      // Back-pressure: both banks fill, then fetching must stop.
      ready_mode = 2;
      d0 = done_cnt; run_start(8'h40, 3);
      repeat (120) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         chk("bp_no_req", mem_req, 0);
         chk("bp_valid", out_valid, 1);
         @(negedge clk);
      end
      ready_mode = 0;
      wait_done(d0);

      // Memory stall on the first request.
      busy_until = cyc + 8;
      d0 = done_cnt; run_start(8'h80, 1); wait_done(d0);

      // Zero-row transfer: done two cycles after start, no requests.
      d0 = done_cnt; run_start(8'h20, 0); wait_done(d0);
      chk("zero_done_lat", last_done_cyc - start_cyc, 2);

      // Start while busy must be ignored.
      d0 = done_cnt; run_start(8'h30, 2);
      repeat (4) @(negedge clk);
      pulse_start(8'h90, 5);
      wait_done(d0);

      // Address wrap.
      d0 = done_cnt; run_start(8'hFC, 1); wait_done(d0);

      // Random traffic with random stalls and back-pressure.
      ready_mode = 1; rnd_busy = 1'b1;
      for (int t = 0; t < 6; t++) begin
         d0 = done_cnt;
         run_start(AW'($urandom), RW'($urandom_range(1, 4)));
         wait_done(d0);
      end

      // Reset in the middle of the first row.
      ready_mode = 0; rnd_busy = 1'b0;
      r0 = rv_cnt; n = 0;
      run_start(8'h50, 2);
      while (rv_cnt - r0 < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("mid_words_seen", (rv_cnt - r0 >= 3), 1);
      @(posedge clk); #3 rst = 1'b0;
      #1 reset_outputs_zero("async");
      exp_addr.delete(); exp_row.delete(); exp_bank.delete();
      bank_par = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      d0 = done_cnt; run_start(8'h60, 2); wait_done(d0);

      chk("rows_pending", exp_row.size(), 0);
      chk("addrs_pending", exp_addr.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
